mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencer for a single MAC datapath (En/Clr/Ain/Bin/Cout, accumulator 3x operand width, product registered on the En edge).
- Accepts a dot-product job of length LEN and pulses MAC clear.
- Streams LEN operand pairs from two valid/ready sources into the MAC, waits for the accumulator to settle, then presents the result on a valid/ready output.
- Sits between the operand fetch logic and the MAC instance.

Parameters:
DATA_WIDTH, 8, operand width of Ain/Bin
LEN_WIDTH, 8, width of job length; max job = 2^LEN_WIDTH-1 beats
ACC_WIDTH, 3*DATA_WIDTH, MAC accumulator/result width (no overflow for LEN<=256 at DATA_WIDTH=8)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  job request; sampled only in IDLE
len  in  LEN_WIDTH  beats in job; latched when start accepted
abort  in  1  synchronous job cancel
a_data  in  DATA_WIDTH  operand A stream
a_valid  in  1  A stream valid
a_ready  out  1  A stream ready
b_data  in  DATA_WIDTH  operand B stream
b_valid  in  1  B stream valid
b_ready  out  1  B stream ready
mac_en  out  1  to MAC En
mac_clr  out  1  to MAC Clr
mac_a  out  DATA_WIDTH  to MAC Ain
mac_b  out  DATA_WIDTH  to MAC Bin
mac_cout  in  ACC_WIDTH  from MAC Cout
res_data  out  ACC_WIDTH  captured dot-product result
res_valid  out  1  result available
res_ready  in  1  result consumer ready
busy  out  1  state != IDLE
beat_cnt  out  LEN_WIDTH  beats consumed in current job

Behaviour:
- Reset (rst=1, asynchronous):
  - State goes to IDLE.
  - beat_cnt, len register, res_data, res_valid, mac_en, mac_clr, a_ready, b_ready, busy all = 0.
- State machine: IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches len and clears beat_cnt; next state CLEAR.
  - start is ignored in every other state.
- CLEAR:
  - mac_clr=1 for exactly one cycle.
  - Next state RUN if latched len!=0, else DRAIN.
- RUN:
  - beat = a_valid & b_valid.
  - a_ready = b_ready = mac_en = beat; ready is 0 in all other states.
  - Joint handshake: neither stream is consumed unless both are valid.
  - mac_a/mac_b = a_data/b_data, combinational pass-through; hold 0 outside RUN.
  - Each beat increments beat_cnt.
  - A beat with beat_cnt==len-1 moves to DRAIN.
  - Bubbles (either valid low) stall without penalty.
- DRAIN:
  - One cycle, during which mac_cout reflects the final accumulation (MAC registers on the En edge).
  - res_data <= mac_cout at the end of DRAIN; next state DONE.
- DONE:
  - res_valid=1 and res_data held stable until res_ready=1.
  - On that handshake cycle, next state is IDLE and res_valid drops the following cycle.
  - No back-to-back bypass: start in the same cycle as the handshake is ignored.
- Latency: start to first possible beat = 2 cycles. Last beat to res_valid = 2 cycles. len=0 job: start to res_valid = 3 cycles, res_data=0.
- abort:
  - Highest priority in any non-IDLE state; next state IDLE.
  - In the abort cycle, mac_en/ready are forced 0 and no beat is consumed.
  - res_valid drops, beat_cnt holds its last value; the MAC is not cleared (the next job's CLEAR does that).
  - abort in IDLE has no effect.
- rst mid-job:
  - Immediate return to IDLE with outputs at reset values.
  - The external MAC has its own reset.
- beat_cnt reads len after a completed job and stays until the next accepted start.
- Arithmetic: beat_cnt is an unsigned LEN_WIDTH compare; it never wraps because the max job is 2^LEN_WIDTH-1.

Decomposition:
- Package mac_seq_pkg holds:
  - state enum (IDLE, CLEAR, RUN, DRAIN, DONE), 3-bit;
  - default width constants DATA_WIDTH=8, LEN_WIDTH=8, ACC_WIDTH=24.
- No sub-module: FSM plus beat counter in one module.
- The MAC is instantiated alongside in the parent, not inside this block.
- Bench instantiates mac_seq_ctrl + MAC together.

Test Plan:
1. len=4, A=3 and B=4 held valid every cycle -> mac_clr one cycle after start, four consecutive mac_en cycles, res_data=48 (0x000030), res_valid 2 cycles after last beat, beat_cnt=4.
2. len=3, A={1,2,3}, B={4,5,6}, b_valid low on alternate cycles -> exactly 3 beats, no consumption while either valid is low, res_data=32 (0x000020).
3. len=0 -> mac_en never asserted, res_valid 3 cycles after start, res_data=0.
4. len=255, A=B=0xFF every cycle -> res_data=0xFD02FF (16581375), no overflow; hold res_ready=0 for 5 cycles -> res_valid and res_data stable; start pulses during DONE ignored.
5. len=8, abort after 3 beats -> busy=0 next cycle, res_valid never asserted, beat_cnt=3. A following len=2 job with 5*6 -> res_data=60, proving CLEAR.
6. Assert rst during RUN -> all outputs 0 asynchronously. After release, a len=1 job with 7*8 -> res_data=56.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared types and default widths for the MAC sequencer.
//   state_t    : sequencer FSM states (3-bit)
//   DATA_WIDTH : default operand width
//   LEN_WIDTH  : default job-length width
//   ACC_WIDTH  : default accumulator/result width
package mac_seq_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int LEN_WIDTH  = 8;
  localparam int ACC_WIDTH  = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one dot-product job through an external MAC.
// Ports:
//   clk, rst            clock, async active-high reset
//   start, len, abort   job request / length / cancel
//   a_*, b_*            operand streams (valid/ready, joint handshake)
//   mac_en/clr/a/b      drive the MAC; mac_cout is its accumulator
//   res_data/valid/ready result output (valid/ready)
//   busy, beat_cnt      status
module mac_seq_ctrl #(
  parameter int DATA_WIDTH = mac_seq_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = mac_seq_pkg::LEN_WIDTH,
  parameter int ACC_WIDTH  = 3 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [ACC_WIDTH-1:0]  mac_cout,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  beat_cnt
);
  import mac_seq_pkg::*;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 in_run;
  logic                 beat;

  // Beats are consumed only when both streams are valid; abort kills the
  // beat in its own cycle so the MAC sees nothing from a cancelled job.
  assign in_run  = (state == RUN);
  assign beat    = in_run & a_valid & b_valid & ~abort;
  assign a_ready = beat;
  assign b_ready = beat;
  assign mac_en  = beat;
  assign mac_a   = in_run ? a_data : '0;
  assign mac_b   = in_run ? b_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      beat_cnt  <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      mac_clr   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      if (abort && state != IDLE) begin
        // beat_cnt and the MAC are left alone; next job's CLEAR resets the MAC
        state     <= IDLE;
        busy      <= 1'b0;
        res_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            len_q    <= len;
            beat_cnt <= '0;
            mac_clr  <= 1'b1;
            busy     <= 1'b1;
            state    <= CLEAR;
          end
          CLEAR: state <= (len_q != '0) ? RUN : DRAIN;
          RUN: if (beat) begin
            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            if (beat_cnt == len_q - LEN_WIDTH'(1)) state <= DRAIN;
          end
          DRAIN: begin
            // MAC has absorbed the last beat on the previous edge
            res_data  <= mac_cout;
            res_valid <= 1'b1;
            state     <= DONE;
          end
          DONE: if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, a_valid, b_valid, res_ready;
  logic [LW-1:0] len;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, mac_en, mac_clr, res_valid, busy;
  logic [DW-1:0] mac_a, mac_b;
  logic [AW-1:0] mac_cout, res_data;
  logic [LW-1:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_cout(mac_cout), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .beat_cnt(beat_cnt)
  );

  // MAC: accumulator updated on the En edge, synchronous clear, own reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mac_cout <= '0;
    else if (mac_clr) mac_cout <= '0;
    else if (mac_en)  mac_cout <= mac_cout + AW'(mac_a) * AW'(mac_b);
  end

  typedef struct {
    int          len;
    int          a0, ainc, b0, binc;
    bit          bubble;
    int          hold;
    logic [AW-1:0] exp;
  } job_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_job(input job_t j);
    int t, beats, clr_cnt, clr_t, first_beat, last_beat, rv_t, bad, unstable;
    logic [AW-1:0] held;
    @(negedge clk);
    start = 1'b1; len = LW'(j.len); res_ready = 1'b0;
    @(posedge clk);
    t = 0; beats = 0; clr_cnt = 0; clr_t = -1; first_beat = -1; last_beat = -1;
    rv_t = -1; bad = 0;
    while (rv_t < 0 && t < 3 * j.len + 20) begin
      @(negedge clk);
      t++;
      start   = 1'b0;
      a_valid = 1'b1;
      b_valid = j.bubble ? (t % 2 == 0) : 1'b1;
      a_data  = DW'(j.a0 + beats * j.ainc);
      b_data  = DW'(j.b0 + beats * j.binc);
      #1;
      if (mac_clr) begin clr_cnt++; clr_t = t; end
      if (mac_en) begin
        if (!b_valid || !a_ready || !b_ready || mac_a !== a_data || mac_b !== b_data) bad++;
        if (first_beat < 0) first_beat = t;
        last_beat = t;
        beats++;
      end else if (a_ready || b_ready) bad++;
      if (res_valid) rv_t = t;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("res_valid_seen", rv_t >= 0, 1);
    chk("beats", beats, j.len);
    chk("handshake_ok", bad, 0);
    chk("clr_pulses", clr_cnt, 1);
    chk("clr_cycle", clr_t, 1);
    if (j.len == 0) chk("len0_latency", rv_t, 3);
    else            chk("last_beat_to_valid", rv_t - last_beat, 2);
    if (!j.bubble && j.len > 0) chk("first_beat_cycle", first_beat, 2);
    chk("res_data", res_data, j.exp);
    chk("beat_cnt", beat_cnt, j.len);
    held = res_data;
    unstable = 0;
    for (int i = 0; i < j.hold; i++) begin
      @(negedge clk);
      start = (i % 2 == 0);
      len   = LW'(5);
      #1;
      if (!res_valid || res_data !== held || beat_cnt !== LW'(j.len)) unstable++;
    end
    if (j.hold > 0) chk("done_hold_stable", unstable, 0);
    // start alongside the result handshake must not launch a new job
    @(negedge clk);
    start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; res_ready = 1'b0;
    #1;
    chk("res_valid_drop", res_valid, 0);
    chk("idle_after_done", busy, 0);
    @(negedge clk);
    #1;
    chk("no_bypass", busy, 0);
  endtask

  job_t jobs[5];

  initial begin
    int beats, guard;
    jobs[0] = '{len: 4,   a0: 3,   ainc: 0, b0: 4,   binc: 0, bubble: 0, hold: 0, exp: 24'd48};
    jobs[1] = '{len: 3,   a0: 1,   ainc: 1, b0: 4,   binc: 1, bubble: 1, hold: 0, exp: 24'd32};
    jobs[2] = '{len: 0,   a0: 9,   ainc: 0, b0: 9,   binc: 0, bubble: 0, hold: 0, exp: 24'd0};
    jobs[3] = '{len: 255, a0: 255, ainc: 0, b0: 255, binc: 0, bubble: 0, hold: 5, exp: 24'hFD02FF};
    jobs[4] = '{len: 1,   a0: 9,   ainc: 0, b0: 11,  binc: 0, bubble: 1, hold: 2, exp: 24'd99};

    rst = 1'b1; start = 0; abort = 0; a_valid = 0; b_valid = 0; res_ready = 0;
    len = '0; a_data = '0; b_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_outs", {mac_en, mac_clr, a_ready, b_ready}, 0);
    rst = 1'b0;
    // abort while idle is a no-op
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1 chk("idle_abort", busy, 0);

    for (int i = 0; i < 5; i++) run_job(jobs[i]);

    // abort after 3 beats of an 8-beat job
    @(negedge clk);
    start = 1'b1; len = LW'(8);
    @(negedge clk);
    start = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'd2; b_data = 8'd2;
    beats = 0; guard = 0;
    while (beats < 3 && guard < 20) begin
      #1 if (mac_en) beats++;
      @(negedge clk);
      guard++;
    end
    chk("abort_setup", beats, 3);
    abort = 1'b1;
    #1;
    chk("abort_blocks_beat", {mac_en, a_ready, b_ready}, 0);
    @(negedge clk);
    abort = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_beat_cnt", beat_cnt, 3);
    guard = 0;
    repeat (4) begin @(negedge clk); #1 if (res_valid || busy) guard++; end
    chk("abort_no_result", guard, 0);
    run_job('{len: 2, a0: 5, ainc: 0, b0: 6, binc: 0, bubble: 0, hold: 0, exp: 24'd60});

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; len = LW'(4);
    @(negedge clk);
    start = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'd1; b_data = 8'd1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {busy, mac_en, mac_clr, a_ready, b_ready, res_valid}, 0);
    chk("async_rst_data", {mac_a, mac_b, beat_cnt}, 0);
    chk("async_rst_res", res_data, 0);
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    run_job('{len: 1, a0: 7, ainc: 0, b0: 8, binc: 0, bubble: 0, hold: 0, exp: 24'd56});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
